// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: default widths, NZCV bit positions,
// EXE command encodings and the control bundle carried EXE -> MEM.
package arm_pkg;

    // Default datapath and register-file address widths
    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 4;

    // NZCV bit positions within the 4-bit status word {N,Z,C,V}
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // EXE command encodings driven to the ALU
    localparam logic [3:0] EXECMD_MOV = 4'b0001;
    localparam logic [3:0] EXECMD_MVN = 4'b1001;
    localparam logic [3:0] EXECMD_ADD = 4'b0010;
    localparam logic [3:0] EXECMD_ADC = 4'b0011;
    localparam logic [3:0] EXECMD_SUB = 4'b0100;
    localparam logic [3:0] EXECMD_SBC = 4'b0101;
    localparam logic [3:0] EXECMD_AND = 4'b0110;
    localparam logic [3:0] EXECMD_ORR = 4'b0111;
    localparam logic [3:0] EXECMD_EOR = 4'b1000;
    localparam logic [3:0] EXECMD_CMP = 4'b0100;
    localparam logic [3:0] EXECMD_TST = 4'b0110;
    localparam logic [3:0] EXECMD_LDR = 4'b0010;
    localparam logic [3:0] EXECMD_STR = 4'b0010;

    // Control bits registered into the MEM stage
    typedef struct packed {
        logic valid;
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
    } mem_ctrl_t;

    localparam mem_ctrl_t MEM_CTRL_BUBBLE = '{valid: 1'b0, wb_en: 1'b0,
                                              mem_r_en: 1'b0, mem_w_en: 1'b0};

endpackage

// File: rtl/exe_stage_reg_status.sv
// Architectural NZCV flag register. Loads only when told to; the output is
// a plain flop so EXE sees new flags the cycle after the update.
module status_register
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Flag storage with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 4'b0000;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/exe_stage_reg.sv
// EXE -> MEM pipeline register. Priority per edge: rst > flush > freeze > load.
// Flush inserts a bubble (controls cleared, data held); freeze holds all state.
// A valid read+write request is demoted to a read and latched in proto_err.
module exe_stage_reg
    import arm_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  exe_valid,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic                  exe_mem_w_en,
    input  logic                  exe_s_bit,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic [DATA_W-1:0]     exe_alu_result,
    input  logic [DATA_W-1:0]     exe_val_rm,
    input  logic [3:0]            alu_status,
    output logic                  mem_valid,
    output logic                  mem_wb_en,
    output logic                  mem_mem_r_en,
    output logic                  mem_mem_w_en,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic [DATA_W-1:0]     mem_alu_result,
    output logic [DATA_W-1:0]     mem_val_rm,
    output logic [3:0]            status_bits,
    output logic                  proto_err
);

    mem_ctrl_t ctrl_q;
    mem_ctrl_t ctrl_d;
    logic      load;
    logic      illegal;
    logic      status_ld;

    // Flush overrides freeze, so a load happens only when neither is asserted
    assign load      = !flush && !freeze;
    assign illegal   = exe_valid && exe_mem_r_en && exe_mem_w_en;
    assign status_ld = load && exe_valid && exe_s_bit;

    // Next control word: gated by valid, write dropped on read+write conflict
    always_comb begin
        ctrl_d          = MEM_CTRL_BUBBLE;
        ctrl_d.valid    = exe_valid;
        ctrl_d.wb_en    = exe_valid && exe_wb_en;
        ctrl_d.mem_r_en = exe_valid && exe_mem_r_en;
        ctrl_d.mem_w_en = exe_valid && exe_mem_w_en && !exe_mem_r_en;
    end

    // Control register: bubble on flush, hold on freeze
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ctrl_q <= MEM_CTRL_BUBBLE;
        else if (flush)
            ctrl_q <= MEM_CTRL_BUBBLE;
        else if (!freeze)
            ctrl_q <= ctrl_d;
    end

    // Data fields: only change on a real load; flush leaves them untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_dest       <= '0;
            mem_alu_result <= '0;
            mem_val_rm     <= '0;
        end else if (load) begin
            mem_dest       <= exe_dest;
            mem_alu_result <= exe_alu_result;
            mem_val_rm     <= exe_val_rm;
        end
    end

    // Sticky protocol error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            proto_err <= 1'b0;
        else if (load && illegal)
            proto_err <= 1'b1;
    end

    assign mem_valid    = ctrl_q.valid;
    assign mem_wb_en    = ctrl_q.wb_en;
    assign mem_mem_r_en = ctrl_q.mem_r_en;
    assign mem_mem_w_en = ctrl_q.mem_w_en;

    status_register u_status (
        .clk (clk),
        .rst (rst),
        .ld  (status_ld),
        .d   (alu_status),
        .q   (status_bits)
    );

endmodule

// File: tb/tb_exe_stage_reg.sv
// Directed bench for exe_stage_reg with an expected-result queue.
module tb_exe_stage_reg;

    typedef struct packed {
        logic        valid;
        logic        wb;
        logic        rd;
        logic        wr;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] rm;
        logic [3:0]  st;
        logic        perr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush;
    logic        exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_s_bit;
    logic [3:0]  exe_dest;
    logic [31:0] exe_alu_result, exe_val_rm;
    logic [3:0]  alu_status;
    logic        mem_valid, mem_wb_en, mem_mem_r_en, mem_mem_w_en;
    logic [3:0]  mem_dest;
    logic [31:0] mem_alu_result, mem_val_rm;
    logic [3:0]  status_bits;
    logic        proto_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    exe_stage_reg #(.DATA_W(32), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .exe_valid(exe_valid), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
        .exe_s_bit(exe_s_bit), .exe_dest(exe_dest),
        .exe_alu_result(exe_alu_result), .exe_val_rm(exe_val_rm),
        .alu_status(alu_status),
        .mem_valid(mem_valid), .mem_wb_en(mem_wb_en),
        .mem_mem_r_en(mem_mem_r_en), .mem_mem_w_en(mem_mem_w_en),
        .mem_dest(mem_dest), .mem_alu_result(mem_alu_result),
        .mem_val_rm(mem_val_rm), .status_bits(status_bits),
        .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step, input exp_t e);
        chk({step, " mem_valid"},      32'(mem_valid),    32'(e.valid));
        chk({step, " mem_wb_en"},      32'(mem_wb_en),    32'(e.wb));
        chk({step, " mem_mem_r_en"},   32'(mem_mem_r_en), 32'(e.rd));
        chk({step, " mem_mem_w_en"},   32'(mem_mem_w_en), 32'(e.wr));
        chk({step, " mem_dest"},       32'(mem_dest),     32'(e.dest));
        chk({step, " mem_alu_result"}, mem_alu_result,    e.alu);
        chk({step, " mem_val_rm"},     mem_val_rm,        e.rm);
        chk({step, " status_bits"},    32'(status_bits),  32'(e.st));
        chk({step, " proto_err"},      32'(proto_err),    32'(e.perr));
    endtask

    task automatic drive(input logic fl, input logic fr, input logic v, input logic wb,
                         input logic r, input logic w, input logic s, input logic [3:0] d,
                         input logic [31:0] a, input logic [31:0] m, input logic [3:0] st);
        flush = fl; freeze = fr; exe_valid = v; exe_wb_en = wb;
        exe_mem_r_en = r; exe_mem_w_en = w; exe_s_bit = s; exe_dest = d;
        exe_alu_result = a; exe_val_rm = m; alu_status = st;
    endtask

    // Expected value is queued with the stimulus, popped after the edge
    task automatic tick(input string step, input exp_t e);
        exp_t got;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() == 1) else begin
            errors++;
            $error("FAIL %s queue_depth observed=%0d expected=1", step, sb.size());
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check_all(step, got);
        end
    endtask

    localparam exp_t ZERO = '0;

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'h0);
        #2;
        check_all("reset", ZERO);
        @(negedge clk);
        rst = 1'b0;

        // plain load
        drive(0, 0, 1, 1, 0, 0, 0, 4'h3, 32'h0000_0010, 32'h0, 4'h0);
        tick("load", '{1, 1, 0, 0, 4'h3, 32'h10, 32'h0, 4'h0, 0});

        // flags update, then an s_bit=0 instruction leaves them alone
        drive(0, 0, 1, 1, 0, 0, 1, 4'h5, 32'h20, 32'h0, 4'b0110);
        tick("flags_set", '{1, 1, 0, 0, 4'h5, 32'h20, 32'h0, 4'b0110, 0});
        drive(0, 0, 1, 1, 0, 0, 0, 4'h6, 32'h30, 32'h0, 4'b1001);
        tick("flags_hold", '{1, 1, 0, 0, 4'h6, 32'h30, 32'h0, 4'b0110, 0});

        // invalid slot: controls gated, data still loads, flags untouched
        drive(0, 0, 0, 1, 1, 0, 1, 4'h7, 32'h40, 32'h0, 4'b1111);
        tick("invalid", '{0, 0, 0, 0, 4'h7, 32'h40, 32'h0, 4'b0110, 0});

        // flush of a valid store
        drive(1, 0, 1, 0, 0, 1, 1, 4'h8, 32'h50, 32'hDEAD_BEEF, 4'b1000);
        tick("flush", '{0, 0, 0, 0, 4'h7, 32'h40, 32'h0, 4'b0110, 0});

        // normal store load
        drive(0, 0, 1, 0, 0, 1, 0, 4'h9, 32'h60, 32'hDEAD_BEEF, 4'b0000);
        tick("store", '{1, 0, 0, 1, 4'h9, 32'h60, 32'hDEAD_BEEF, 4'b0110, 0});

        // three frozen edges with changing inputs
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1, 0, 0, 1, 4'hA, 32'h70 + i, 32'(i), 4'b0011 + 4'(i));
            tick("freeze", '{1, 0, 0, 1, 4'h9, 32'h60, 32'hDEAD_BEEF, 4'b0110, 0});
        end
        drive(0, 0, 1, 1, 0, 0, 1, 4'hA, 32'h72, 32'h2, 4'b0101);
        tick("unfreeze", '{1, 1, 0, 0, 4'hA, 32'h72, 32'h2, 4'b0101, 0});

        // flush together with freeze behaves as flush
        drive(1, 1, 1, 1, 1, 0, 1, 4'hC, 32'h90, 32'h9, 4'b1111);
        tick("flush_freeze", '{0, 0, 0, 0, 4'hA, 32'h72, 32'h2, 4'b0101, 0});

        // read+write conflict
        drive(0, 0, 1, 1, 1, 1, 0, 4'hB, 32'h80, 32'h8, 4'b0000);
        tick("illegal", '{1, 1, 1, 0, 4'hB, 32'h80, 32'h8, 4'b0101, 1});
        drive(0, 0, 1, 1, 0, 0, 1, 4'h1, 32'h84, 32'h0, 4'b1010);
        tick("sticky", '{1, 1, 0, 0, 4'h1, 32'h84, 32'h0, 4'b1010, 1});
        drive(0, 0, 0, 0, 1, 1, 0, 4'h2, 32'h88, 32'h0, 4'b0000);
        tick("invalid_rw", '{0, 0, 0, 0, 4'h2, 32'h88, 32'h0, 4'b1010, 1});

        // async reset between edges, held through a freeze
        drive(0, 1, 1, 1, 0, 0, 1, 4'h4, 32'hF0, 32'hF1, 4'b1100);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset", ZERO);
        @(negedge clk);
        rst = 1'b0;
        tick("post_reset_freeze", ZERO);
        drive(0, 0, 1, 0, 1, 0, 1, 4'hD, 32'hA0, 32'hA1, 4'b1100);
        tick("post_reset_load", '{1, 0, 1, 0, 4'hD, 32'hA0, 32'hA1, 4'b1100, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_stage_reg.md
EXE_STAGE_REG -- requirements
Module: exe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of result and store data.
REQ-002 Parameter REG_ADDR_W, default 4, register-file address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 freeze  input  1  hold all state (downstream memory stall).
REQ-006 flush  input  1  replace incoming EXE content with a bubble.
REQ-007 exe_valid  input  1  EXE slot holds a real instruction.
REQ-008 exe_wb_en, exe_mem_r_en, exe_mem_w_en  input  1 each  control bits from EXE.
REQ-009 exe_s_bit  input  1  instruction updates NZCV.
REQ-010 exe_dest  input  REG_ADDR_W  writeback register.
REQ-011 exe_alu_result  input  DATA_W  ALU result or memory address.
REQ-012 exe_val_rm  input  DATA_W  store data.
REQ-013 alu_status  input  4  ALU NZCV, order {N,Z,C,V}.
REQ-014 mem_valid, mem_wb_en, mem_mem_r_en, mem_mem_w_en  output  1 each  registered controls to MEM.
REQ-015 mem_dest, mem_alu_result, mem_val_rm  output  widths as inputs  registered data to MEM.
REQ-016 status_bits  output  4  architectural NZCV; feeds ALU status input and condition check.
REQ-017 proto_err  output  1  sticky: illegal control combination captured.

Function
REQ-018 Priority per edge: rst > flush > freeze > load.
REQ-019 Load (no flush, no freeze): every mem_* output takes its exe_* input next edge; latency exactly 1 cycle.
REQ-020 Control outputs gated: mem_wb_en, mem_mem_r_en, mem_mem_w_en SHALL be 0 whenever loaded exe_valid is 0.
REQ-021 Flush: mem_valid, mem_wb_en, mem_mem_r_en, mem_mem_w_en cleared next edge; data outputs hold previous value; status_bits unchanged.
REQ-022 Freeze (no flush): all outputs, status_bits and proto_err hold.
REQ-023 status_bits loads alu_status on an edge only when exe_valid=1, exe_s_bit=1, flush=0, freeze=0; otherwise holds.
REQ-024 status_bits is visible to EXE the cycle after update; no combinational bypass of alu_status.
REQ-025 exe_mem_r_en=1 and exe_mem_w_en=1 on a loading valid edge: read kept, write dropped (mem_mem_w_en=0), proto_err set.
REQ-026 proto_err cleared only by rst.
REQ-027 Flush and freeze asserted together: flush behaviour (REQ-021) applies.
REQ-028 No combinational path from any input to any output.

Reset
REQ-029 rst asserted: immediately, without clock, all outputs 0, including status_bits=4'b0000 and proto_err=0.
REQ-030 rst mid-freeze or mid-flush: reset wins; first edge after deassertion follows REQ-018.

Structure
REQ-031 Shared package arm_pkg holds NZCV bit index constants (N=3, Z=2, C=1, V=0), DATA_W and REG_ADDR_W defaults, and EXECMD encodings.
REQ-032 One sub-module, status_register: 4-bit flop, async active-high reset, load enable from REQ-023.
REQ-033 Pipeline fields and proto_err logic live in exe_stage_reg itself.

Verification
REQ-034 Load: exe_valid=1, wb_en=1, dest=4'h3, alu_result=32'h0000_0010 -> next edge mem_valid=1, mem_wb_en=1, mem_dest=3, mem_alu_result=32'h10.
REQ-035 Flags: exe_valid=1, s_bit=1, alu_status=4'b0110 -> status_bits=4'b0110 next edge; following instruction s_bit=0, alu_status=4'b1001 -> status_bits stays 4'b0110.
REQ-036 Flush: load valid store (mem_w_en=1, val_rm=32'hDEAD_BEEF) with flush=1, s_bit=1, alu_status=4'b1000 -> mem_valid=0, mem_mem_w_en=0, status_bits unchanged.
REQ-037 Freeze: 3 cycles freeze=1 with changing inputs -> all outputs constant; first unfrozen edge loads current inputs.
REQ-038 Illegal: exe_valid=1, mem_r_en=1, mem_w_en=1 -> mem_mem_r_en=1, mem_mem_w_en=0, proto_err=1, stays 1 until rst.
REQ-039 Async reset: assert rst between edges while outputs nonzero -> all outputs 0 before next edge, status_bits=0.
